heap_node_ctrl: RTL and testbench
=================================

# heap_node_ctrl

Sequencing controller for one sort node of the pipelined heap sorter. It sits at level LEVEL and carries a sift-down token. It reads the two child slots of the token's position from the level LEVEL+1 `data_store_delay`, which has one-cycle read latency. It then writes the winner into its own level's store and, on a swap, forwards the displaced value to the next level's controller over a valid/ready handshake. The heap is a max-heap on unsigned keys; empty slots hold 0.

## Interface
- `DATA_WIDTH`, 32, key width (unsigned).
- `ADDR_WIDTH`, 5, slot address width of each store memory.
- `LEVEL`, 1, heap level served by this node.
- `LAST`, 0, 1 = bottom level: no child store, never forwards.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  token from upper node.
- `req_ready`  out  1  token accepted when `req_valid & req_ready`.
- `req_data`  in  DATA_WIDTH  value being sifted.
- `req_addr`  in  ADDR_WIDTH  slot address at this level.
- `req_branch`  in  1  0 = left memory, 1 = right memory.
- `busy`  out  1  state != IDLE; feeds the upper node's `dn_busy`.
- `st_din`  out  DATA_WIDTH  write data to own level store (bottom port).
- `st_addr`  out  ADDR_WIDTH  own store address.
- `st_branch`  out  1  own store memory select.
- `st_we`  out  1  own store write enable, single-cycle pulse.
- `ch_addr`  out  ADDR_WIDTH  child address to next level store (both lm and rm up ports).
- `ch_l_dout`  in  DATA_WIDTH  left child read data (one-cycle latency).
- `ch_r_dout`  in  DATA_WIDTH  right child read data.
- `dn_valid`  out  1  token to lower node.
- `dn_ready`  in  1  lower node accepts.
- `dn_data`, `dn_addr`, `dn_branch`  out  DATA_WIDTH / ADDR_WIDTH / 1  forwarded token.
- `dn_busy`  in  1  lower node's `busy`; tie 0 when LAST=1.

## Operation
- FSM states:
  - IDLE → READ on accept.
  - READ → CMP unconditionally.
  - CMP → SEND if swap, else CMP → IDLE.
  - SEND → IDLE on `dn_valid & dn_ready`.
- `req_ready` = (state == IDLE) & !`dn_busy`. Blocking on `dn_busy` prevents reading a child slot that the lower node has not yet rewritten.
- On accept, latch V = `req_data`, A = `req_addr`, B = `req_branch`.
- `ch_addr` = {A[ADDR_WIDTH-2:0], B}, driven from the latched registers in READ and CMP; 0 otherwise.
- CMP compares L = `ch_l_dout` and R = `ch_r_dout` (forced to 0 when LAST=1):
  - Child select: C = L, side S = 0, if L >= R (ties go left); else C = R, S = 1.
  - If C > V (strict, unsigned), swap:
    - `st_we`=1, `st_din`=C, `st_addr`=A, `st_branch`=B.
    - Register the down token: data V, addr `ch_addr`, branch S.
  - Otherwise no swap:
    - `st_we`=1, `st_din`=V, `st_addr`=A, `st_branch`=B.
    - Sift terminates.
- SEND holds `dn_valid` and the token stable until `dn_ready`. `dn_ready` while not in SEND is ignored.
- LAST=1: swap is never taken, `dn_valid` stays 0, and `ch_addr` remains don't-care.
- Reset, including mid-operation: state → IDLE.
  - `st_we`, `dn_valid`, and `busy` are 0 in the cycle after `rst`.
  - All data/address outputs reset to 0.
  - An in-flight token is dropped with no write. `req_ready` reflects `dn_busy` once `rst` falls.

## Timing
- Cycle T: accept. T+1: READ, `ch_addr` valid. T+2: CMP; child data valid, `st_we` pulses.
- No swap: IDLE at T+3; `req_ready` can be high at T+3. Minimum initiation interval is 3 cycles.
- Swap: `dn_valid` rises at T+3. With `dn_ready` high, handshake completes at T+3 and the node is IDLE at T+4. Each cycle of `dn_ready` stall adds one cycle.
- Exactly one `st_we` pulse per accepted token.
- `busy` is high in READ, CMP and SEND.

## Test plan
- No swap: accept V=50, A=3, B=1 with children L=10, R=20 → `ch_addr`=7 at T+1; at T+2 `st_we`=1, `st_din`=50, `st_addr`=3, `st_branch`=1; no `dn_valid`; `req_ready`=1 at T+3.
- Right swap: V=5, A=2, B=0, L=9, R=30 → at T+2 `st_din`=30 to (2,0); at T+3 `dn_valid` with data 5, addr 4, branch 1.
- Tie and backpressure: V=1, L=R=8 → left chosen (branch 0); hold `dn_ready`=0 for 4 cycles → token stable and `dn_valid` high throughout; IDLE the cycle after the handshake.
- Hazard interlock: `dn_busy`=1 with `req_valid`=1 → `req_ready`=0 and no accept until `dn_busy` falls; accept occurs in the first cycle `dn_busy`=0.
- LAST=1: V=3, children driven to 0xFFFFFFFF → `st_din`=3 and `dn_valid` never asserts.
- Reset in CMP: assert `rst` at T+2 → no `st_we` in any cycle after the reset edge; `dn_valid`=0 and `busy`=0; a fresh token afterward completes normally.

Source files
------------

// File: rtl/heap_node_if.sv
// Handshake and store/child bus of one heap sort node.
// slave = the node controller, master = upper node / stores / lower node.
interface heap_node_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_data;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_branch;
    logic                  busy;
    logic [DATA_WIDTH-1:0] st_din;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic                  st_branch;
    logic                  st_we;
    logic [ADDR_WIDTH-1:0] ch_addr;
    logic [DATA_WIDTH-1:0] ch_l_dout;
    logic [DATA_WIDTH-1:0] ch_r_dout;
    logic                  dn_valid;
    logic                  dn_ready;
    logic [DATA_WIDTH-1:0] dn_data;
    logic [ADDR_WIDTH-1:0] dn_addr;
    logic                  dn_branch;
    logic                  dn_busy;

    modport master (
        output req_valid, req_data, req_addr, req_branch,
        output ch_l_dout, ch_r_dout, dn_ready, dn_busy,
        input  req_ready, busy, st_din, st_addr, st_branch, st_we,
        input  ch_addr, dn_valid, dn_data, dn_addr, dn_branch
    );

    modport slave (
        input  req_valid, req_data, req_addr, req_branch,
        input  ch_l_dout, ch_r_dout, dn_ready, dn_busy,
        output req_ready, busy, st_din, st_addr, st_branch, st_we,
        output ch_addr, dn_valid, dn_data, dn_addr, dn_branch
    );
endinterface

// File: rtl/heap_node_ctrl.sv
// Sift-down controller for one level of the pipelined max-heap sorter:
// reads both children, writes the winner locally, forwards the loser downward.
module heap_node_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LEVEL      = 1,
    parameter bit LAST       = 1'b0
) (
    input logic       clk,
    input logic       rst,
    heap_node_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, CMP, SEND} state_t;

    state_t state;

    logic [DATA_WIDTH-1:0] v_p0;
    logic [ADDR_WIDTH-1:0] a_p0;
    logic                  b_p0;
    logic [ADDR_WIDTH-1:0] ch_addr_p0;
    logic [DATA_WIDTH-1:0] dn_data_p1;
    logic [ADDR_WIDTH-1:0] dn_addr_p1;
    logic                  dn_branch_p1;

    logic [DATA_WIDTH-1:0] l_data;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH:0]   pick;
    logic [DATA_WIDTH-1:0] c_data;
    logic                  c_side;
    logic                  swap;
    logic                  accept;
    logic                  vld_p0;
    logic                  vld_p1;
    logic                  vld_p2;

    // Larger child wins, ties go left; MSB of the result is the side.
    function automatic logic [DATA_WIDTH:0] pick_child(input logic [DATA_WIDTH-1:0] l,
                                                       input logic [DATA_WIDTH-1:0] r);
        if (l >= r) return {1'b0, l};
        return {1'b1, r};
    endfunction

    // A bottom-level node has no child store; a negative LEVEL is treated the same.
    if (LAST || LEVEL < 0) begin : g_leaf
        assign l_data = '0;
        assign r_data = '0;
    end else begin : g_inner
        assign l_data = bus.ch_l_dout;
        assign r_data = bus.ch_r_dout;
    end

    assign pick   = pick_child(l_data, r_data);
    assign c_data = pick[DATA_WIDTH-1:0];
    assign c_side = pick[DATA_WIDTH];
    assign swap   = !LAST && (c_data > v_p0);

    assign accept = (state == IDLE) && bus.req_valid && !bus.dn_busy;
    assign vld_p0 = (state == READ) || (state == CMP);
    assign vld_p1 = (state == CMP);
    assign vld_p2 = (state == SEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= READ;
                READ:    state <= CMP;
                CMP:     state <= swap ? SEND : IDLE;
                SEND:    if (bus.dn_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p0: token latched on accept; child address issued during READ/CMP
    always_ff @(posedge clk) begin
        if (accept) begin
            v_p0       <= bus.req_data;
            a_p0       <= bus.req_addr;
            b_p0       <= bus.req_branch;
            ch_addr_p0 <= {bus.req_addr[ADDR_WIDTH-2:0], bus.req_branch};
        end
    end

    // Stage p1 -> p2: displaced value captured for the lower node on a swap
    always_ff @(posedge clk) begin
        if (vld_p1 && swap) begin
            dn_data_p1   <= v_p0;
            dn_addr_p1   <= ch_addr_p0;
            dn_branch_p1 <= c_side;
        end
    end

    assign bus.req_ready = (state == IDLE) && !bus.dn_busy;
    assign bus.busy      = (state != IDLE);
    assign bus.ch_addr   = vld_p0 ? ch_addr_p0 : '0;

    assign bus.st_we     = vld_p1;
    assign bus.st_din    = vld_p1 ? (swap ? c_data : v_p0) : '0;
    assign bus.st_addr   = vld_p1 ? a_p0 : '0;
    assign bus.st_branch = vld_p1 && b_p0;

    assign bus.dn_valid  = vld_p2;
    assign bus.dn_data   = vld_p2 ? dn_data_p1 : '0;
    assign bus.dn_addr   = vld_p2 ? dn_addr_p1 : '0;
    assign bus.dn_branch = vld_p2 && dn_branch_p1;
endmodule

// File: tb/tb_heap_node_ctrl.sv
// Directed and randomized bench for heap_node_ctrl against a sift-step model.
module tb_heap_node_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [DW-1:0] lmem [0:(1<<AW)-1];
    logic [DW-1:0] rmem [0:(1<<AW)-1];

    heap_node_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    heap_node_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) leaf ();

    heap_node_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEVEL(1), .LAST(1'b0)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    heap_node_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEVEL(4), .LAST(1'b1)) dut_last (
        .clk(clk), .rst(rst), .bus(leaf));

    always #5 clk = ~clk;

    // Child store with one-cycle read latency
    always @(posedge clk) begin
        bus.ch_l_dout <= lmem[bus.ch_addr];
        bus.ch_r_dout <= rmem[bus.ch_addr];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sift step: starts and ends 1 time unit after a rising edge.
    task automatic do_token(input logic [DW-1:0] v, input logic [AW-1:0] a, input logic b,
                            input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int stall, input int hold);
        logic [AW-1:0] ca;
        logic [DW-1:0] c;
        logic          s, sw;
        ca = {a[AW-2:0], b};
        lmem[ca] = l;
        rmem[ca] = r;
        if (l >= r) begin c = l; s = 1'b0; end
        else begin c = r; s = 1'b1; end
        sw = (c > v);
        bus.req_data = v; bus.req_addr = a; bus.req_branch = b;
        bus.dn_ready = 1'($urandom_range(0, 1));
        for (int k = 0; k < hold; k++) begin
            bus.dn_busy = 1'b1; bus.req_valid = 1'b1;
            @(negedge clk); chk("hold_req_ready", bus.req_ready, 0);
            @(posedge clk); #1; chk("hold_busy", bus.busy, 0);
        end
        bus.dn_busy = 1'b0; bus.req_valid = 1'b1;
        @(negedge clk); chk("acc_req_ready", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_data = $urandom;
        @(negedge clk);
        chk("read_busy", bus.busy, 1);
        chk("read_ch_addr", bus.ch_addr, ca);
        chk("read_st_we", bus.st_we, 0);
        @(posedge clk); #1;
        bus.dn_ready = (stall == 0);
        @(negedge clk);
        chk("cmp_st_we", bus.st_we, 1);
        chk("cmp_st_din", bus.st_din, sw ? c : v);
        chk("cmp_st_addr", bus.st_addr, a);
        chk("cmp_st_branch", bus.st_branch, b);
        chk("cmp_dn_valid", bus.dn_valid, 0);
        @(posedge clk); #1;
        if (sw) begin
            for (int k = 0; k <= stall; k++) begin
                @(negedge clk);
                chk("send_dn_valid", bus.dn_valid, 1);
                chk("send_dn_data", bus.dn_data, v);
                chk("send_dn_addr", bus.dn_addr, ca);
                chk("send_dn_branch", bus.dn_branch, s);
                chk("send_st_we", bus.st_we, 0);
                @(posedge clk); #1;
                if (k == stall - 1) bus.dn_ready = 1'b1;
            end
            bus.dn_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("done_busy", bus.busy, 0);
        chk("done_dn_valid", bus.dn_valid, 0);
        chk("done_st_we", bus.st_we, 0);
        chk("done_req_ready", bus.req_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin lmem[i] = '0; rmem[i] = '0; end
        bus.req_valid = 0; bus.req_data = '0; bus.req_addr = '0; bus.req_branch = 0;
        bus.dn_ready = 0; bus.dn_busy = 0;
        leaf.req_valid = 0; leaf.req_data = '0; leaf.req_addr = '0; leaf.req_branch = 0;
        leaf.dn_ready = 1; leaf.dn_busy = 0; leaf.ch_l_dout = '1; leaf.ch_r_dout = '1;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_st_we", bus.st_we, 0);
        chk("rst_dn_valid", bus.dn_valid, 0);
        chk("rst_ch_addr", bus.ch_addr, 0);
        chk("rst_st_din", bus.st_din, 0);
        chk("rst_dn_data", bus.dn_data, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        @(posedge clk); #1;

        // Directed cases: no swap, right swap, tie with backpressure, hazard interlock
        do_token(32'd50, 5'd3, 1'b1, 32'd10, 32'd20, 0, 0);
        do_token(32'd5, 5'd2, 1'b0, 32'd9, 32'd30, 0, 0);
        do_token(32'd1, 5'd6, 1'b1, 32'd8, 32'd8, 4, 0);
        do_token(32'd7, 5'd17, 1'b0, 32'd3, 32'd4, 0, 3);
        do_token(32'd0, 5'd31, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 2);
        do_token(32'hFFFF_FFFF, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);

        // Bottom-level node never swaps even with maximal children
        leaf.req_valid = 1; leaf.req_data = 32'd3; leaf.req_addr = 5'd3; leaf.req_branch = 0;
        @(negedge clk); chk("last_req_ready", leaf.req_ready, 1);
        @(posedge clk); #1 leaf.req_valid = 0;
        @(negedge clk); chk("last_busy", leaf.busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("last_st_we", leaf.st_we, 1);
        chk("last_st_din", leaf.st_din, 32'd3);
        chk("last_dn_valid", leaf.dn_valid, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("last_idle_dn_valid", leaf.dn_valid, 0);
            chk("last_idle_busy", leaf.busy, 0);
        end
        @(posedge clk); #1;

        // Reset while in CMP drops a token that would otherwise swap
        lmem[5'd9] = 32'd40; rmem[5'd9] = 32'd1;
        bus.req_valid = 1; bus.req_data = 32'd2; bus.req_addr = 5'd4; bus.req_branch = 1;
        bus.dn_ready = 1;
        @(posedge clk); #1 bus.req_valid = 0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); chk("rcmp_pre_st_we", bus.st_we, 1);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rcmp_st_we", bus.st_we, 0);
            chk("rcmp_dn_valid", bus.dn_valid, 0);
            chk("rcmp_busy", bus.busy, 0);
            chk("rcmp_st_din", bus.st_din, 0);
            chk("rcmp_dn_data", bus.dn_data, 0);
            chk("rcmp_ch_addr", bus.ch_addr, 0);
        end
        @(posedge clk); #1;
        do_token(32'd2, 5'd4, 1'b1, 32'd40, 32'd1, 0, 0);

        // Randomized tokens: small key range forces ties and both outcomes
        for (int n = 0; n < 30; n++) begin
            logic [DW-1:0] v, l, r;
            if ($urandom_range(0, 3) == 0) begin
                v = $urandom; l = $urandom; r = $urandom;
            end else begin
                v = $urandom_range(0, 12); l = $urandom_range(0, 12);
                r = ($urandom_range(0, 3) == 0) ? l : DW'($urandom_range(0, 12));
            end
            do_token(v, AW'($urandom), 1'($urandom), l, r,
                     $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
